// File: rtl/cpu_pkg.sv
// Shared types and constants for the basic-computer control sequencer.
// Op vector bit positions are shared by the decoder and the FSM.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_INDIRECT = 3'd3,
    ST_EXEC     = 3'd4,
    ST_HALT     = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STA = 3'b011;
  localparam logic [2:0] OP_BUN = 3'b100;
  localparam logic [2:0] OP_ISZ = 3'b110;
  localparam logic [2:0] OP_REG = 3'b111;

  localparam logic [3:0] RR_CLA = 4'h0;
  localparam logic [3:0] RR_CLE = 4'h1;
  localparam logic [3:0] RR_CMA = 4'h2;
  localparam logic [3:0] RR_LDI = 4'h3;
  localparam logic [3:0] RR_CIR = 4'h4;
  localparam logic [3:0] RR_CIL = 4'h5;
  localparam logic [3:0] RR_INC = 4'h6;
  localparam logic [3:0] RR_HLT = 4'h7;

  localparam int NUM_OPS = 14;
  localparam int B_ADD = 0;
  localparam int B_LDA = 1;
  localparam int B_STA = 2;
  localparam int B_BUN = 3;
  localparam int B_ISZ = 4;
  localparam int B_CLA = 5;
  localparam int B_CLE = 6;
  localparam int B_CMA = 7;
  localparam int B_LDI = 8;
  localparam int B_CIR = 9;
  localparam int B_CIL = 10;
  localparam int B_INC = 11;
  localparam int B_HLT = 12;
  localparam int B_NOP = 13;

  typedef logic [NUM_OPS-1:0] op_vec_t;

  typedef struct packed {
    op_vec_t    op;
    logic [1:0] sc_lim;
    logic       mem_ref;
  } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational IR decode: one-hot op vector, EXEC cycle limit, memory-reference flag.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] ir_hi,
  output dec_t       dec
);

  always_comb begin
    dec        = '0;
    dec.sc_lim = 2'd1;
    case (ir_hi[6:4])
      OP_ADD: begin dec.op[B_ADD] = 1'b1; dec.sc_lim = 2'd2; dec.mem_ref = 1'b1; end
      OP_LDA: begin dec.op[B_LDA] = 1'b1; dec.sc_lim = 2'd2; dec.mem_ref = 1'b1; end
      OP_STA: begin dec.op[B_STA] = 1'b1; dec.mem_ref = 1'b1; end
      OP_BUN: begin dec.op[B_BUN] = 1'b1; dec.mem_ref = 1'b1; end
      OP_ISZ: begin dec.op[B_ISZ] = 1'b1; dec.sc_lim = 2'd3; dec.mem_ref = 1'b1; end
      OP_REG: begin
        // 111 with I set carries no register-reference meaning
        if (ir_hi[7]) dec.op[B_NOP] = 1'b1;
        else begin
          case (ir_hi[3:0])
            RR_CLA:  dec.op[B_CLA] = 1'b1;
            RR_CLE:  dec.op[B_CLE] = 1'b1;
            RR_CMA:  dec.op[B_CMA] = 1'b1;
            RR_LDI:  dec.op[B_LDI] = 1'b1;
            RR_CIR:  dec.op[B_CIR] = 1'b1;
            RR_CIL:  dec.op[B_CIL] = 1'b1;
            RR_INC:  dec.op[B_INC] = 1'b1;
            RR_HLT:  dec.op[B_HLT] = 1'b1;
            default: dec.op[B_NOP] = 1'b1;
          endcase
        end
      end
      default: dec.op[B_NOP] = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/indirect/execute control FSM with memory-wait timeout.
// Optional indirect addressing phase enabled by CPU_SEQ_INDIRECT_EN.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int SC_WIDTH     = 3
) (
  input  logic                clk,
  input  logic                i_clr_reg,
  input  logic                i_start,
  input  logic [15:0]         i_ir,
  input  logic                i_mem_ready,
  input  logic                i_ex_done,
  output logic                o_fetch,
  output logic                o_execute,
  output logic                o_is_ind,
  output logic                o_is_dir,
  output logic                o_clr_ac,
  output logic                o_clr_e,
  output logic                o_comp_ac,
  output logic                o_load_ac,
  output logic                o_cir_r,
  output logic                o_cir_l,
  output logic                o_inc_ac,
  output logic                o_add,
  output logic                o_load,
  output logic                o_store,
  output logic                o_branch,
  output logic                o_isz,
  output logic [SC_WIDTH-1:0] o_sc,
  output logic [2:0]          o_state,
  output logic                o_halt,
  output logic                o_err
);

  localparam int WW = $clog2(MEM_WAIT_MAX + 2);

  state_t        state, nxt;
  logic [WW-1:0] wait_cnt;
  dec_t          dec;
  op_vec_t       op_q, op_nxt;
  logic [1:0]    lim_q, lim_nxt;
  logic          mem_q, mem_nxt;
  logic          timeout, ex_end, err_set, go_ind, in_exec;
  logic          unused_ir;

  assign unused_ir = ^i_ir[7:0];
  assign o_state   = state;

  instr_decoder u_dec (.ir_hi(i_ir[15:8]), .dec(dec));

`ifdef CPU_SEQ_INDIRECT_EN
  assign go_ind = i_ir[15] && (i_ir[14:12] != OP_REG);
`else
  assign go_ind = 1'b0;
`endif

  always_comb begin
    timeout = (wait_cnt == WW'(MEM_WAIT_MAX));
    ex_end  = i_ex_done || (o_sc == SC_WIDTH'(lim_q));
    nxt     = state;
    err_set = 1'b0;
    case (state)
      ST_IDLE:   if (i_start) nxt = ST_FETCH;
      // ready is checked first so it wins over a same-cycle timeout
      ST_FETCH:  if (i_mem_ready) nxt = ST_DECODE;
                 else if (timeout) begin nxt = ST_HALT; err_set = 1'b1; end
      ST_DECODE: nxt = go_ind ? ST_INDIRECT : ST_EXEC;
`ifdef CPU_SEQ_INDIRECT_EN
      ST_INDIRECT: if (i_mem_ready) nxt = ST_EXEC;
                   else if (timeout) begin nxt = ST_HALT; err_set = 1'b1; end
`endif
      ST_EXEC:   if (op_q[B_HLT]) nxt = ST_HALT;
                 else if (ex_end) nxt = ST_FETCH;
      ST_HALT:   if (i_start) nxt = ST_FETCH;
      default:   nxt = ST_IDLE;
    endcase
    // decode is captured on the DECODE cycle; later cycles reuse the held copy
    op_nxt  = (state == ST_DECODE) ? dec.op      : op_q;
    lim_nxt = (state == ST_DECODE) ? dec.sc_lim  : lim_q;
    mem_nxt = (state == ST_DECODE) ? dec.mem_ref : mem_q;
    in_exec = (nxt == ST_EXEC);
  end

  always_ff @(posedge clk or posedge i_clr_reg) begin
    if (i_clr_reg) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      op_q      <= '0;
      lim_q     <= '0;
      mem_q     <= 1'b0;
      o_sc      <= '0;
      o_fetch   <= 1'b0;
      o_execute <= 1'b0;
      o_is_dir  <= 1'b0;
      o_clr_ac  <= 1'b0;
      o_clr_e   <= 1'b0;
      o_comp_ac <= 1'b0;
      o_load_ac <= 1'b0;
      o_cir_r   <= 1'b0;
      o_cir_l   <= 1'b0;
      o_inc_ac  <= 1'b0;
      o_add     <= 1'b0;
      o_load    <= 1'b0;
      o_store   <= 1'b0;
      o_branch  <= 1'b0;
      o_isz     <= 1'b0;
      o_halt    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state <= nxt;
      op_q  <= op_nxt;
      lim_q <= lim_nxt;
      mem_q <= mem_nxt;
      if (nxt == state && (state == ST_FETCH || state == ST_INDIRECT))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (in_exec) o_sc <= (state == ST_EXEC) ? o_sc + 1'b1 : SC_WIDTH'(1);
      else         o_sc <= '0;
      o_fetch   <= (nxt == ST_FETCH);
      o_execute <= in_exec;
      o_is_dir  <= in_exec && mem_nxt;
      o_clr_ac  <= in_exec && op_nxt[B_CLA];
      o_clr_e   <= in_exec && op_nxt[B_CLE];
      o_comp_ac <= in_exec && op_nxt[B_CMA];
      o_load_ac <= in_exec && op_nxt[B_LDI];
      o_cir_r   <= in_exec && op_nxt[B_CIR];
      o_cir_l   <= in_exec && op_nxt[B_CIL];
      o_inc_ac  <= in_exec && op_nxt[B_INC];
      o_add     <= in_exec && op_nxt[B_ADD];
      o_load    <= in_exec && op_nxt[B_LDA];
      o_store   <= in_exec && op_nxt[B_STA];
      o_branch  <= in_exec && op_nxt[B_BUN];
      o_isz     <= in_exec && op_nxt[B_ISZ];
      o_halt    <= (nxt == ST_HALT);
      if (err_set) o_err <= 1'b1;
    end
  end

`ifdef CPU_SEQ_INDIRECT_EN
  always_ff @(posedge clk or posedge i_clr_reg) begin
    if (i_clr_reg) o_is_ind <= 1'b0;
    else           o_is_ind <= (nxt == ST_INDIRECT);
  end
`else
  assign o_is_ind = 1'b0;
`endif

endmodule
